// File: rtl/conv_serializer_scheduler.sv
// conv_serializer_scheduler: round-robin front end for one conv tree serializer.
// It grants one requester per frame and holds the granted word on SER_PAR_IN
// for FRAME_CYCLES clocks. It then flushes the tree with zeros for FLUSH_CYCLES
// clocks before dropping SER_EN. A new word may be accepted on the last shift
// cycle, which gives back-to-back frames, or at any point during the flush.
module conv_serializer_scheduler #(
    parameter int WIDTH        = 256,
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = WIDTH / 2,
    parameter int FLUSH_CYCLES = $clog2(WIDTH),
    parameter int REQ_W        = $clog2(NUM_REQ)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]         REQ_READY,
    output logic [WIDTH-1:0]           SER_PAR_IN,
    output logic                       SER_EN,
    output logic                       FRAME_START,
    output logic [REQ_W-1:0]           FRAME_OWNER,
    output logic                       BUSY
);

    localparam int CNT_MAX = (FRAME_CYCLES > FLUSH_CYCLES) ? FRAME_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [REQ_W-1:0] REQ_LAST   = REQ_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [REQ_W-1:0]   ptr, nxt_ptr;
    logic [WIDTH-1:0]   nxt_par;
    logic               nxt_en, nxt_start;
    logic [REQ_W-1:0]   nxt_owner;

    logic               accept_win;
    logic               gnt_found;
    logic [REQ_W-1:0]   gnt_idx;
    logic               xfer;

    // Round-robin search starting at the pointer and wrapping. It looks at valids only.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && REQ_VALID[(int'(ptr) + i) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = REQ_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    // Accept window and one-hot grant; nothing is granted while reset is asserted.
    always_comb begin
        accept_win = 1'b0;
        if (!RESET) begin
            case (state)
                IDLE:    accept_win = 1'b1;
                FLUSH:   accept_win = 1'b1;
                SHIFT:   accept_win = (cnt == FRAME_LAST);
                default: accept_win = 1'b0;
            endcase
        end
        REQ_READY = '0;
        if (accept_win && gnt_found)
            REQ_READY[gnt_idx] = 1'b1;
    end

    assign xfer = accept_win && gnt_found;

    // Next-state and next-output logic. A transfer takes priority over the
    // frame and flush timeouts.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_ptr   = ptr;
        nxt_par   = SER_PAR_IN;
        nxt_en    = SER_EN;
        nxt_start = 1'b0;
        nxt_owner = FRAME_OWNER;
        if (xfer) begin
            nxt_state = SHIFT;
            nxt_cnt   = '0;
            nxt_par   = REQ_DATA[gnt_idx*WIDTH +: WIDTH];
            nxt_owner = gnt_idx;
            nxt_en    = 1'b1;
            nxt_start = 1'b1;
            nxt_ptr   = (gnt_idx == REQ_LAST) ? '0 : gnt_idx + 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == FRAME_LAST) begin
                        // Word is done; feed zeros so the tree drains.
                        nxt_state = FLUSH;
                        nxt_cnt   = '0;
                        nxt_par   = '0;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        nxt_state = IDLE;
                        nxt_cnt   = '0;
                        nxt_en    = 1'b0;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    // State and output registers. Reset drops any frame in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= '0;
            SER_PAR_IN  <= '0;
            SER_EN      <= 1'b0;
            FRAME_START <= 1'b0;
            FRAME_OWNER <= '0;
            BUSY        <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            ptr         <= nxt_ptr;
            SER_PAR_IN  <= nxt_par;
            SER_EN      <= nxt_en;
            FRAME_START <= nxt_start;
            FRAME_OWNER <= nxt_owner;
            BUSY        <= (nxt_state != IDLE);
        end
    end

endmodule
